vga_fb_write_ctrl: RTL

- Sequencer and arbiter for the VGA framebuffer write port: the `adress`, `adat` and `we` inputs of the VGA module (8192 x 4-bit pixel RAM, 128x64).
- Two requesters share the port: a single-pixel valid/ready stream (game/draw logic) and a built-in rectangle-fill engine (clear screen, draw boxes).
- Drives one registered framebuffer write per cycle at most.

---
 rtl/vga_fb_write_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vga_fb_write_ctrl.sv
// Framebuffer write-port sequencer: arbitrates a single-pixel stream against a
// rectangle-fill engine. Optional macro VGA_FB_VBLANK_ONLY_EN restricts grants to vblank.
module vga_fb_write_ctrl #(
  parameter int X_W = 7,
  parameter int Y_W = 6,
  parameter int D_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               px_valid,
  output logic               px_ready,
  input  logic [X_W-1:0]     px_x,
  input  logic [Y_W-1:0]     px_y,
  input  logic [D_W-1:0]     px_color,
  input  logic               fill_start,
  input  logic [X_W-1:0]     fill_x0,
  input  logic [X_W-1:0]     fill_x1,
  input  logic [Y_W-1:0]     fill_y0,
  input  logic [Y_W-1:0]     fill_y1,
  input  logic [D_W-1:0]     fill_color,
  output logic               fill_busy,
  output logic               fill_done,
  input  logic               vblank,
  output logic [X_W+Y_W-1:0] fb_adress,
  output logic [D_W-1:0]     fb_adat,
  output logic               fb_we
);

  typedef enum logic {IDLE, FILL} state_e;

  state_e             state_q, state_d;
  logic               rr_q, rr_d;  // 1: pixel wins the next contended cycle
  logic [X_W-1:0]     xmin_q, xmin_d, xmax_q, xmax_d, cx_q, cx_d;
  logic [Y_W-1:0]     ymin_q, ymin_d, ymax_q, ymax_d, cy_q, cy_d;
  logic [D_W-1:0]     color_q, color_d;
  logic [X_W+Y_W-1:0] adr_q, adr_d;
  logic [D_W-1:0]     dat_q, dat_d;
  logic               we_q, we_d;
  logic               done_q, done_d;
  logic               gate, px_grant, fill_grant, last_pix;

`ifdef VGA_FB_VBLANK_ONLY_EN
  assign gate = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate = 1'b1;
`endif

  assign last_pix = (cx_q == xmax_q) && (cy_q == ymax_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      color_q <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      color_q <= color_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill_start) state_d = FILL;
      FILL:    if (fill_grant && last_pix) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // px_ready depends only on state, rr bit and gate, never on px_valid
  always_comb begin
    px_ready = 1'b0;
    if (!rst && gate) begin
      case (state_q)
        IDLE:    px_ready = 1'b1;
        FILL:    px_ready = rr_q;
        default: px_ready = 1'b0;
      endcase
    end
    px_grant   = px_valid && px_ready;
    fill_grant = !rst && gate && (state_q == FILL) && !px_grant;
  end

  always_comb begin
    rr_d    = rr_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    color_d = color_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = px_grant || fill_grant;
    done_d  = fill_grant && last_pix;
    if (px_grant) begin
      rr_d  = 1'b0;
      adr_d = {px_y, px_x};
      dat_d = px_color;
    end
    if (fill_grant) begin
      rr_d  = 1'b1;
      adr_d = {cy_q, cx_q};
      dat_d = color_q;
      if (cx_q == xmax_q) begin
        cx_d = xmin_q;
        cy_d = cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
    if (state_q == IDLE && fill_start) begin
      xmin_d  = (fill_x0 < fill_x1) ? fill_x0 : fill_x1;
      xmax_d  = (fill_x0 < fill_x1) ? fill_x1 : fill_x0;
      ymin_d  = (fill_y0 < fill_y1) ? fill_y0 : fill_y1;
      ymax_d  = (fill_y0 < fill_y1) ? fill_y1 : fill_y0;
      cx_d    = xmin_d;
      cy_d    = ymin_d;
      color_d = fill_color;
    end
  end

  assign fill_busy = (state_q == FILL);
  assign fill_done = done_q;
  assign fb_adress = adr_q;
  assign fb_adat   = dat_q;
  assign fb_we     = we_q;

endmodule
